line_fill_mem_ctrl: RTL and testbench
=====================================

Name: line_fill_mem_ctrl

Overview:
Backing-memory controller downstream of the cache.
- Serves 512-bit line refills on a miss and accepts dirty-line writebacks on eviction.
- Holds the line array internally and models a fixed access latency.
- Uses a request/ready, valid/ack handshake so the cache control FSM can stall until the fill data arrives.

Parameters:
- LINE_W, 512, data line width in bits.
- ADDR_W, 32, byte address width.
- OFFSET_W, 6, byte-offset bits within a line; these are ignored.
- DEPTH_LOG2, 8, log2 of the number of lines held.
- LATENCY, 4, cycles from accept to completion of one access; legal range 1..15.

Ports:
- clk, in, 1: clock; all logic is on the rising edge.
- rst, in, 1: synchronous active-high reset.
- rd_req, in, 1: line fill request.
- rd_addr, in, ADDR_W: fill address.
- wr_req, in, 1: writeback request.
- wr_addr, in, ADDR_W: writeback address.
- wr_data, in, LINE_W: writeback line.
- ready, out, 1: controller idle and able to accept a request.
- rd_valid, out, 1: fill data valid; held until acknowledged.
- rdata, out, LINE_W: fill line.
- rd_ack, in, 1: cache consumed rdata.
- wr_done, out, 1: one-cycle pulse when the writeback is committed to the array.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Line index is addr[OFFSET_W+DEPTH_LOG2-1:OFFSET_W].
  - Offset bits are ignored.
  - Upper bits are ignored, so addresses alias modulo the array depth.
- Reset values: state=IDLE, rd_valid=0, wr_done=0, rdata=0, latency counter=0, pending-read flag=0.
  - ready=0 while rst is high and 1 on the first cycle after reset.
  - Array contents are not cleared.
- ready = (state==IDLE) & ~rst. Requests are sampled only when ready=1; requests made while ready=0 are dropped, not queued.
- States: IDLE, WR_WAIT, RD_WAIT, RESP.
- IDLE:
  - wr_req=1: latch wr_addr and wr_data, load counter with LATENCY-1, go to WR_WAIT.
  - rd_req=1 in the same cycle: also latch rd_addr and set pending-read.
  - rd_req only: latch rd_addr, load counter, go to RD_WAIT.
- WR_WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0: write the array and pulse wr_done.
  - Then, if pending-read is set, clear it, reload the counter and go to RD_WAIT; otherwise go to IDLE.
- RD_WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0: register the array line into rdata, set rd_valid=1 and go to RESP.
- RESP:
  - rd_valid and rdata are held stable until rd_ack=1.
  - On that cycle, rd_valid drops on the next edge and the state returns to IDLE. rdata keeps its last value.
  - rd_ack while rd_valid=0 is ignored.
- Latency: accept at cycle T.
  - Write only: wr_done at T+LATENCY.
  - Read only: rd_valid at T+LATENCY.
  - Combined request: wr_done at T+LATENCY, rd_valid at T+2*LATENCY.
  - Minimum return to ready is one cycle after the ack.
- Simultaneous write and read always run writeback-first. If both map to the same index, the fill returns the newly written data.
- Reset mid-operation:
  - Abort and return to IDLE with the reset values above.
  - An uncommitted write is discarded and the array is unchanged.
  - A pending fill is dropped.
- LATENCY=1: the counter loads 0 and completion happens on the first wait-state cycle.

Test Plan:
1. Reset, then wr_req with wr_addr=0x0000_0040 and wr_data={16{32'hA5A5_0001}}; LATENCY=4 -> ready=0 at T+1, wr_done pulse at T+4 only, ready=1 at T+5.
2. rd_req with rd_addr=0x0000_0047 (offset ignored) after test 1 -> rd_valid=1 at T+4 with rdata={16{32'hA5A5_0001}}; held 3 cycles while rd_ack=0; drops one cycle after rd_ack=1.
3. wr_req and rd_req together, both addresses 0x0000_4080 (index 2, aliasing with 0x80), wr_data=512'h1234 -> wr_done at T+4, rd_valid at T+8 with rdata=512'h1234.
4. rd_req asserted while ready=0 during an active access -> request ignored; no extra rd_valid after the first response completes.
5. wr_req to index 3 with new data, rst pulsed at T+2 -> no wr_done; ready=1 after reset; a read of index 3 returns the old contents.
6. LATENCY=1 rebuild, read-only request -> rd_valid at T+1; back-to-back ack and a new request are accepted on the first cycle ready=1.

Source files
------------

// File: rtl/line_fill_mem_ctrl.sv
// Backing-memory controller: serves line fills and accepts dirty-line writebacks
// against an internal line array with a fixed access latency.
//
// Handshake: ready=1 means the controller samples rd_req/wr_req on this edge;
// requests seen while ready=0 are dropped. rd_valid stays high with rdata
// stable until the edge on which rd_ack=1 is sampled. wr_done is a one-cycle
// pulse on commit.
module line_fill_mem_ctrl #(
   parameter int LINE_W     = 512,
   parameter int ADDR_W     = 32,
   parameter int OFFSET_W   = 6,
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [LINE_W-1:0] wr_data,
   output logic              ready,
   output logic              rd_valid,
   output logic [LINE_W-1:0] rdata,
   input  logic              rd_ack,
   output logic              wr_done,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_WAIT = 2'd1,
      RD_WAIT = 2'd2,
      RESP    = 2'd3
   } state_t;

   localparam int              CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   state_t                  state, state_next;
   logic [CNT_W-1:0]        cnt, cnt_next;
   logic                    pend_rd, pend_rd_next;
   logic                    rd_valid_next;
   logic                    accept_wr, accept_rd;
   logic                    wr_commit, rd_commit;
   logic [DEPTH_LOG2-1:0]   wr_idx, rd_idx;
   logic [LINE_W-1:0]       wr_line;
   logic [LINE_W-1:0]       mem [2**DEPTH_LOG2];

   // Offset and upper address bits deliberately do not select a line.
   logic addr_unused;
   assign addr_unused = ^{rd_addr[ADDR_W-1:OFFSET_W+DEPTH_LOG2], rd_addr[OFFSET_W-1:0],
                          wr_addr[ADDR_W-1:OFFSET_W+DEPTH_LOG2], wr_addr[OFFSET_W-1:0]};

   assign ready     = (state == IDLE) & ~rst;
   assign dbg_state = state;

   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      pend_rd_next  = pend_rd;
      rd_valid_next = rd_valid;
      accept_wr     = 1'b0;
      accept_rd     = 1'b0;
      wr_commit     = 1'b0;
      rd_commit     = 1'b0;
      case (state)
         IDLE: begin
            if (ready && wr_req) begin
               accept_wr  = 1'b1;
               cnt_next   = CNT_LOAD;
               state_next = WR_WAIT;
               if (rd_req) begin
                  accept_rd    = 1'b1;
                  pend_rd_next = 1'b1;
               end
            end else if (ready && rd_req) begin
               accept_rd  = 1'b1;
               cnt_next   = CNT_LOAD;
               state_next = RD_WAIT;
            end
         end
         WR_WAIT: begin
            if (cnt == '0) begin
               wr_commit = 1'b1;
               // Writeback always lands before a bundled fill, so same-index fills see new data.
               if (pend_rd) begin
                  pend_rd_next = 1'b0;
                  cnt_next     = CNT_LOAD;
                  state_next   = RD_WAIT;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         RD_WAIT: begin
            if (cnt == '0) begin
               rd_commit     = 1'b1;
               rd_valid_next = 1'b1;
               state_next    = RESP;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         RESP: begin
            if (rd_ack) begin
               rd_valid_next = 1'b0;
               state_next    = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         pend_rd  <= 1'b0;
         rd_valid <= 1'b0;
         wr_done  <= 1'b0;
         rdata    <= '0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         pend_rd  <= pend_rd_next;
         rd_valid <= rd_valid_next;
         wr_done  <= wr_commit;
         if (rd_commit) rdata <= mem[rd_idx];
      end
   end

   // Array only changes on commit, so a reset before commit leaves it untouched.
   always_ff @(posedge clk) begin
      if (accept_wr) begin
         wr_idx  <= wr_addr[OFFSET_W+DEPTH_LOG2-1:OFFSET_W];
         wr_line <= wr_data;
      end
      if (accept_rd) rd_idx <= rd_addr[OFFSET_W+DEPTH_LOG2-1:OFFSET_W];
      if (wr_commit && !rst) mem[wr_idx] <= wr_line;
   end

endmodule

// File: tb/tb_line_fill_mem_ctrl.sv
// Bench for line_fill_mem_ctrl: LATENCY=4 instance for the main sequence and a
// LATENCY=1 instance for the minimum-latency turnaround.
module tb_line_fill_mem_ctrl;
   localparam int LINE_W = 512;
   localparam int ADDR_W = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic              rd_req, wr_req, rd_ack, ready, rd_valid, wr_done;
   logic [ADDR_W-1:0] rd_addr, wr_addr;
   logic [LINE_W-1:0] wr_data, rdata;
   logic [1:0]        dbg_state;

   logic              rd_req_b, wr_req_b, rd_ack_b, ready_b, rd_valid_b, wr_done_b;
   logic [ADDR_W-1:0] rd_addr_b, wr_addr_b;
   logic [LINE_W-1:0] wr_data_b, rdata_b;
   logic [1:0]        dbg_state_b;

   line_fill_mem_ctrl #(.LATENCY(4)) dut (
      .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .wr_req(wr_req),
      .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready), .rd_valid(rd_valid),
      .rdata(rdata), .rd_ack(rd_ack), .wr_done(wr_done), .dbg_state(dbg_state)
   );

   line_fill_mem_ctrl #(.LATENCY(1)) dut_b (
      .clk(clk), .rst(rst), .rd_req(rd_req_b), .rd_addr(rd_addr_b), .wr_req(wr_req_b),
      .wr_addr(wr_addr_b), .wr_data(wr_data_b), .ready(ready_b), .rd_valid(rd_valid_b),
      .rdata(rdata_b), .rd_ack(rd_ack_b), .wr_done(wr_done_b), .dbg_state(dbg_state_b)
   );

   int vectors = 0;
   int miscompares = 0;
   logic [LINE_W-1:0] exp_q[$];
   logic [LINE_W-1:0] model_a [int];
   logic [LINE_W-1:0] model_b [int];

   task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int idx_of(input logic [ADDR_W-1:0] a);
      return int'((a >> 6) & 32'hFF);
   endfunction

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic pop_check(input string tag, input logic [LINE_W-1:0] got);
      logic [LINE_W-1:0] e;
      check({tag, "_qsize"}, exp_q.size(), 1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check(tag, got, e);
      end
   endtask

   // Write on the LATENCY=4 instance: wr_done only 4 edges after accept, ready back by then.
   task automatic write_a(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data);
      wr_addr = addr;
      wr_data = data;
      wr_req  = 1'b1;
      step();
      wr_req = 1'b0;
      model_a[idx_of(addr)] = data;
      for (int k = 1; k <= 5; k++) begin
         step();
         check($sformatf("wr_done_k%0d", k), wr_done, (k == 4));
         if (k == 1) check("wr_busy", ready, 1'b0);
         if (k == 5) check("wr_ready_back", ready, 1'b1);
      end
   endtask

   // Read on the LATENCY=4 instance with hold_cycles of rd_ack=0 after rd_valid.
   task automatic read_a(input logic [ADDR_W-1:0] addr, input int hold_cycles);
      logic [LINE_W-1:0] line;
      line = model_a[idx_of(addr)];
      exp_q.push_back(line);
      rd_addr = addr;
      rd_req  = 1'b1;
      step();
      rd_req = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("rd_valid_k%0d", k), rd_valid, (k == 4));
      end
      pop_check("rdata", rdata);
      for (int h = 0; h < hold_cycles; h++) begin
         step();
         check("rd_valid_hold", rd_valid, 1'b1);
         check("rdata_hold", rdata, line);
      end
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
      check("rd_valid_after_ack", rd_valid, 1'b0);
      check("ready_after_ack", ready, 1'b1);
      check("rdata_kept", rdata, line);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LINE_W-1:0] old_line, new_line, l5, l6;
      int extra;

      rst = 1'b1;
      rd_req = 1'b0; wr_req = 1'b0; rd_ack = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
      rd_req_b = 1'b0; wr_req_b = 1'b0; rd_ack_b = 1'b0;
      rd_addr_b = '0; wr_addr_b = '0; wr_data_b = '0;

      // Reset state
      step();
      step();
      check("rst_ready", ready, 1'b0);
      check("rst_ready_b", ready_b, 1'b0);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_wr_done", wr_done, 1'b0);
      check("rst_rdata", rdata, '0);
      check("rst_state", dbg_state, 2'd0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", ready, 1'b1);
      check("ready_b_after_rst", ready_b, 1'b1);

      // Writeback then fill through an offset-bearing address
      write_a(32'h0000_0040, {16{32'hA5A5_0001}});
      read_a(32'h0000_0047, 3);

      // Combined request, same aliased index: writeback first, fill sees new data
      wr_addr = 32'h0000_4080;
      rd_addr = 32'h0000_4080;
      wr_data = 512'h1234;
      wr_req = 1'b1;
      rd_req = 1'b1;
      step();
      wr_req = 1'b0;
      rd_req = 1'b0;
      model_a[idx_of(32'h0000_4080)] = 512'h1234;
      exp_q.push_back(model_a[idx_of(32'h0000_4080)]);
      for (int k = 1; k <= 8; k++) begin
         step();
         check($sformatf("comb_wr_done_k%0d", k), wr_done, (k == 4));
         check($sformatf("comb_rd_valid_k%0d", k), rd_valid, (k == 8));
      end
      pop_check("comb_rdata", rdata);
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
      check("comb_ack", rd_valid, 1'b0);

      // Read issued while busy is dropped
      exp_q.push_back(model_a[idx_of(32'h0000_0080)]);
      rd_addr = 32'h0000_0080;
      rd_req = 1'b1;
      step();
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("busy_ready_k%0d", k), ready, 1'b0);
         check($sformatf("busy_rd_valid_k%0d", k), rd_valid, (k == 4));
         if (k == 2) rd_req = 1'b0;
      end
      pop_check("busy_rdata", rdata);
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
      extra = 0;
      for (int k = 0; k < 12; k++) begin
         if (rd_valid) extra++;
         step();
      end
      check("dropped_read_extra_valid", extra, 0);
      check("dropped_read_ready", ready, 1'b1);

      // Reset during an uncommitted writeback
      old_line = rand_line();
      new_line = ~old_line;
      write_a(32'h0000_00C0, old_line);
      wr_addr = 32'h0000_00C0;
      wr_data = new_line;
      wr_req = 1'b1;
      step();
      wr_req = 1'b0;
      step();
      rst = 1'b1;
      #1;
      check("ready_in_rst", ready, 1'b0);
      step();
      rst = 1'b0;
      #1;
      check("abort_ready", ready, 1'b1);
      check("abort_state", dbg_state, 2'd0);
      check("abort_rd_valid", rd_valid, 1'b0);
      check("abort_rdata", rdata, '0);
      extra = 0;
      for (int k = 0; k < 8; k++) begin
         if (wr_done) extra++;
         step();
      end
      check("abort_no_wr_done", extra, 0);
      read_a(32'h0000_00C0, 0);

      // LATENCY=1: completion on the first wait cycle, re-accept right after ack
      l5 = rand_line();
      l6 = rand_line();
      wr_addr_b = 32'h0000_0140;
      wr_data_b = l5;
      wr_req_b = 1'b1;
      step();
      wr_req_b = 1'b0;
      model_b[idx_of(32'h0000_0140)] = l5;
      step();
      check("b_wr_done_k1", wr_done_b, 1'b1);
      step();
      check("b_wr_done_k2", wr_done_b, 1'b0);
      wr_addr_b = 32'h0000_0180;
      wr_data_b = l6;
      wr_req_b = 1'b1;
      step();
      wr_req_b = 1'b0;
      model_b[idx_of(32'h0000_0180)] = l6;
      step();
      check("b_wr2_done", wr_done_b, 1'b1);

      exp_q.push_back(model_b[idx_of(32'h0000_0140)]);
      rd_addr_b = 32'h0000_0140;
      rd_req_b = 1'b1;
      step();
      rd_req_b = 1'b0;
      step();
      check("b_rd_valid_k1", rd_valid_b, 1'b1);
      pop_check("b_rdata1", rdata_b);
      rd_ack_b = 1'b1;
      step();
      rd_ack_b = 1'b0;
      check("b_ack_valid", rd_valid_b, 1'b0);
      check("b_ack_ready", ready_b, 1'b1);
      exp_q.push_back(model_b[idx_of(32'h0000_0180)]);
      rd_addr_b = 32'h0000_0180;
      rd_req_b = 1'b1;
      step();
      rd_req_b = 1'b0;
      check("b_reaccept_busy", ready_b, 1'b0);
      step();
      check("b_rd2_valid_k1", rd_valid_b, 1'b1);
      pop_check("b_rdata2", rdata_b);
      rd_ack_b = 1'b1;
      step();
      rd_ack_b = 1'b0;
      check("b_ack2_valid", rd_valid_b, 1'b0);
      check("q_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
